// File: rtl/mv_host_ctrl.sv
// Host-side controller for matrixvect_mult: start handshake, then drain both y banks onto a valid/ready stream.
// Optional handshake watchdog enabled by defining MV_TIMEOUT_EN.
module mv_host_ctrl #(
    parameter int unsigned ADDR_Y_SIZE    = 12,
    parameter int unsigned WORDS_PER_BANK = 64,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_req,
    output logic                   busy,
    output logic                   done_pulse,
    output logic                   err,
    output logic [31:0]            ps_control,
    input  logic [31:0]            pl_status,
    output logic [ADDR_Y_SIZE-1:0] bram_addr_y,
    input  logic [31:0]            bram_rddata_y1,
    input  logic [31:0]            bram_rddata_y2,
    output logic [31:0]            bram_wrdata_y,
    output logic [3:0]             bram_we_y,
    output logic [31:0]            out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last
);

    localparam int unsigned IDX_W = $clog2(WORDS_PER_BANK) + 1;

    if (WORDS_PER_BANK == 0 || TIMEOUT_CYCLES == 0 ||
        4 * WORDS_PER_BANK > 2 ** ADDR_Y_SIZE) begin : g_bad_params
        $error("mv_host_ctrl: invalid parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ACK, S_RD_ISSUE, S_RD_WAIT, S_EMIT1, S_EMIT2
    } state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [31:0]            h2, h2_nxt;
    logic [31:0]            out_data_nxt;
    logic [ADDR_Y_SIZE-1:0] addr_nxt;
    logic                   busy_nxt, done_nxt, err_nxt, ps_start_nxt;
    logic                   out_valid_nxt, out_last_nxt;
    logic                   hs, last_word, pl_done, timeout_hit;
    logic                   unused_pl;

    assign hs        = out_valid & out_ready;
    assign last_word = (idx == IDX_W'(WORDS_PER_BANK - 1));
    assign pl_done   = pl_status[0];
    assign unused_pl = &{1'b0, pl_status[31:1]};

    assign bram_wrdata_y = '0;
    assign bram_we_y     = '0;

`ifdef MV_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    // Watchdog counts cycles spent in the current START/ACK visit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (state_nxt != state) begin
            to_cnt <= '0;
        end else if (state == S_START || state == S_ACK) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign timeout_hit = (state == S_START || state == S_ACK) &&
                         (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            h2          <= '0;
            busy        <= 1'b0;
            done_pulse  <= 1'b0;
            err         <= 1'b0;
            ps_control  <= '0;
            bram_addr_y <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            h2          <= h2_nxt;
            busy        <= busy_nxt;
            done_pulse  <= done_nxt;
            err         <= err_nxt;
            ps_control  <= {31'b0, ps_start_nxt};
            bram_addr_y <= addr_nxt;
            out_data    <= out_data_nxt;
            out_valid   <= out_valid_nxt;
            out_last    <= out_last_nxt;
        end
    end

    // Next-state and word index
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            S_IDLE:     if (start_req) state_nxt = S_START;
            S_START: begin
                if (pl_done)          state_nxt = S_ACK;
                else if (timeout_hit) state_nxt = S_IDLE;
            end
            S_ACK: begin
                if (!pl_done) begin
                    state_nxt = S_RD_ISSUE;
                    idx_nxt   = '0;
                end else if (timeout_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_RD_ISSUE: state_nxt = S_RD_WAIT;
            S_RD_WAIT:  state_nxt = S_EMIT1;
            S_EMIT1:    if (hs) state_nxt = S_EMIT2;
            S_EMIT2: begin
                if (hs) begin
                    if (last_word) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_RD_ISSUE;
                        idx_nxt   = idx + IDX_W'(1);
                    end
                end
            end
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state
    always_comb begin
        busy_nxt      = (state_nxt != S_IDLE);
        ps_start_nxt  = (state_nxt == S_START);
        out_valid_nxt = (state_nxt == S_EMIT1) || (state_nxt == S_EMIT2);
        out_last_nxt  = (state_nxt == S_EMIT2) && (idx_nxt == IDX_W'(WORDS_PER_BANK - 1));
        done_nxt      = (state == S_EMIT2) && hs && last_word;
        err_nxt       = err | (timeout_hit && state_nxt == S_IDLE);
        h2_nxt        = h2;
        out_data_nxt  = out_data;
        addr_nxt      = bram_addr_y;
        if (state == S_RD_WAIT) begin
            out_data_nxt = bram_rddata_y1;
            h2_nxt       = bram_rddata_y2;
        end else if (state == S_EMIT1 && hs) begin
            out_data_nxt = h2;
        end
        if (state_nxt == S_RD_ISSUE) begin
            addr_nxt = ADDR_Y_SIZE'({idx_nxt, 2'b00});
        end
    end

endmodule

// File: doc/mv_host_ctrl.md
Name: mv_host_ctrl

Overview:
- Host-side counterpart of the matrixvect_mult control/result interface.
- Raises ps_control[0] on request and completes the four-phase handshake against pl_status[0].
- Then acts as the reader of the two y result BRAMs (bank 1, bank 2) and streams the words out on a valid/ready interface.
- Sits between the accelerator and a downstream consumer (DMA / AXI-Stream packer), replacing the software poll-and-read loop.

Parameters:
- ADDR_Y_SIZE, 12, byte-address width of the y BRAM ports.
- WORDS_PER_BANK, 64, 32-bit words read from each y bank; requires 4*WORDS_PER_BANK <= 2**ADDR_Y_SIZE.
- TIMEOUT_CYCLES, 65535, handshake watchdog limit (used only with MV_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start_req  in  1  single-cycle request to run one multiply and drain results
- busy  out  1  high from accepted start_req until return to IDLE
- done_pulse  out  1  one-cycle pulse after the last word handshakes
- err  out  1  sticky watchdog error (MV_TIMEOUT_EN only)
- ps_control  out  32  to accelerator; bit0 = start, bits[31:1] = 0
- pl_status  in  32  from accelerator; bit0 = done, other bits ignored
- bram_addr_y  out  ADDR_Y_SIZE  byte read address, shared by both y banks
- bram_rddata_y1  in  32  bank-1 read data, 1-cycle registered BRAM latency
- bram_rddata_y2  in  32  bank-2 read data, 1-cycle registered BRAM latency
- bram_wrdata_y  out  32  constant 0
- bram_we_y  out  4  constant 4'h0; the block never writes
- out_data  out  32  result word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_last  out  1  high with the final word of a run

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, word index 0, err 0.
- All outputs are registered. Reset mid-operation aborts immediately, drops ps_control, and discards held data.
- IDLE: start_req=1 -> START with ps_control=1 and busy=1 from the next cycle. start_req is ignored in all other states.
- START: hold ps_control[0]=1 until pl_status[0]=1 is sampled -> ACK with ps_control=0.
- ACK: wait for pl_status[0]=0 -> RD_ISSUE with index i=0.
- RD_ISSUE: drive bram_addr_y = 4*i (zero-extended) -> RD_WAIT.
- RD_WAIT: BRAM data is valid this cycle. Capture y1 and y2 into hold regs h1/h2 at the clock edge -> EMIT1.
- EMIT1: out_valid=1, out_data=h1. On handshake -> EMIT2.
- EMIT2: out_valid=1, out_data=h2, out_last=(i==WORDS_PER_BANK-1). On handshake:
  - if last: -> IDLE, done_pulse=1 for one cycle, busy=0;
  - else: i++, -> RD_ISSUE.
- Output order: y1[0], y2[0], y1[1], y2[1], ..., total 2*WORDS_PER_BANK words.
- While out_valid=1 and out_ready=0: out_data, out_valid and out_last hold stable; no word is dropped or duplicated.
- pl_status[0] already 1 on entry to START: advance to ACK on the first START cycle (ps_control is still high for at least one cycle).
- bram_addr_y holds its last value outside RD_ISSUE. It is don't-care to consumers but must not be X.
- Index counter width is clog2(WORDS_PER_BANK)+1. No wrap occurs because the run ends at WORDS_PER_BANK-1.

Optional Feature:
- Macro: MV_TIMEOUT_EN.
- Defined: a cycle counter runs in START and ACK and clears on each state entry. Reaching TIMEOUT_CYCLES forces ps_control=0, sets err=1 (sticky until reset), and returns to IDLE with busy=0 and no done_pulse. A later start_req is accepted with err still 1.
- Undefined: no counter; START/ACK wait indefinitely; err is tied to 0.

Test Plan:
- Reset: hold reset=0 for 4 cycles -> ps_control=0, busy=0, out_valid=0, bram_we_y=0, err=0; release -> remains IDLE.
- Normal run: WORDS_PER_BANK=4; model asserts pl_status[0] 10 cycles after ps_control[0] and drops it 2 cycles after ps_control falls; y1[i]=i, y2[i]=0x100+i; out_ready=1 -> stream 0,0x100,1,0x101,2,0x102,3,0x103; out_last only on 0x103; addresses 0,4,8,12; single done_pulse.
- Backpressure: same run with out_ready toggling pseudo-randomly (~50%) -> identical 8-word sequence, out_data stable whenever valid&&!ready, no duplicates.
- start_req pulsed during ACK and during EMIT1 -> ignored; exactly one run and one done_pulse.
- Reset asserted mid-stream after 3 words -> all outputs 0 asynchronously. A new start_req then yields the full 8 words from address 0.
- MV_TIMEOUT_EN with TIMEOUT_CYCLES=20 and pl_status held 0 -> ps_control falls 20 cycles after START entry, err=1, busy=0, no done_pulse.
